// File: rtl/config_frame_pkg.sv
// rtl/config_frame_pkg.sv - shared constants, state enum and header check for the frame loader
package config_frame_pkg;

    localparam int DefaultFrameBits = 32;
    localparam int DefaultMaxFrames = 20;
    localparam int FrameIdxWidth    = $clog2(DefaultMaxFrames);

    localparam logic [15:0] SyncWord = 16'hFAB0;

    localparam int SyncHi  = 31;
    localparam int SyncLo  = 16;
    localparam int CountHi = 15;
    localparam int CountLo = 8;
    localparam int StartHi = 7;
    localparam int StartLo = 0;

    typedef enum logic [2:0] {
        HDR,
        DATA_WAIT,
        SETUP,
        STROBE,
        HOLD
    } LoaderState;

    // The end index is formed at 9 bits so start+count cannot wrap past the limit.
    function automatic logic headerValid(input logic [31:0] word, input int maxFrames);
        logic [8:0] endIdx;
        endIdx = {1'b0, word[CountHi:CountLo]} + {1'b0, word[StartHi:StartLo]};
        return (word[SyncHi:SyncLo] == SyncWord)
            && (word[CountHi:CountLo] != 8'd0)
            && (endIdx <= 9'(maxFrames));
    endfunction

endpackage

// File: rtl/config_frame_loader.sv
// rtl/config_frame_loader.sv - header-decoded word stream to one-hot frame-latch strobes
module config_frame_loader
    import config_frame_pkg::*;
#(
    parameter int FrameBitsPerRow = DefaultFrameBits,
    parameter int MaxFramesPerCol = DefaultMaxFrames
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [FrameBitsPerRow-1:0] InData,
    input  logic                       InValid,
    output logic                       InReady,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       Busy,
    output logic                       Done,
    output logic                       ErrorFlag
);

    LoaderState state;
    LoaderState nextState;

    logic [FrameIdxWidth-1:0]   idx;
    logic [7:0]                 remaining;
    logic                       readyState;
    logic                       accept;
    logic                       hdrOk;
    logic [MaxFramesPerCol-1:0] strobeOneHot;

    assign hdrOk        = headerValid(InData, MaxFramesPerCol);
    assign InReady      = readyState & ~RST;
    assign accept       = InReady & InValid;
    assign Busy         = (state != HDR);
    assign strobeOneHot = MaxFramesPerCol'(1) << idx;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= HDR;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState  = state;
        readyState = 1'b0;
        case (state)
            HDR: begin
                readyState = 1'b1;
                if (accept && hdrOk) begin
                    nextState = DATA_WAIT;
                end
            end
            DATA_WAIT: begin
                readyState = 1'b1;
                if (accept) begin
                    nextState = SETUP;
                end
            end
            SETUP:   nextState = STROBE;
            STROBE:  nextState = HOLD;
            HOLD:    nextState = (remaining == 8'd1) ? HDR : DATA_WAIT;
            default: nextState = HDR;
        endcase
    end

    // Strobe is loaded while in SETUP so it is high exactly for the STROBE cycle,
    // with FrameData already settled one full cycle earlier.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            FrameData   <= '0;
            FrameStrobe <= '0;
            idx         <= '0;
            remaining   <= '0;
            Done        <= 1'b0;
            ErrorFlag   <= 1'b0;
        end else begin
            Done        <= 1'b0;
            FrameStrobe <= '0;
            case (state)
                HDR: begin
                    if (accept) begin
                        if (hdrOk) begin
                            idx       <= InData[StartLo +: FrameIdxWidth];
                            remaining <= InData[CountHi:CountLo];
                            ErrorFlag <= 1'b0;
                        end else begin
                            ErrorFlag <= 1'b1;
                        end
                    end
                end
                DATA_WAIT: begin
                    if (accept) begin
                        FrameData <= InData;
                    end
                end
                SETUP: begin
                    FrameStrobe <= strobeOneHot;
                end
                HOLD: begin
                    remaining <= remaining - 8'd1;
                    idx       <= idx + FrameIdxWidth'(1);
                    if (remaining == 8'd1) begin
                        Done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_config_frame_loader.sv
// tb/tb_config_frame_loader.sv - scoreboard bench for config_frame_loader
module tb_config_frame_loader;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] InData = 32'h0;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [31:0] FrameData;
    logic [19:0] FrameStrobe;
    logic        Busy;
    logic        Done;
    logic        ErrorFlag;

    config_frame_loader dut (
        .CLK        (CLK),
        .RST        (RST),
        .InData     (InData),
        .InValid    (InValid),
        .InReady    (InReady),
        .FrameData  (FrameData),
        .FrameStrobe(FrameStrobe),
        .Busy       (Busy),
        .Done       (Done),
        .ErrorFlag  (ErrorFlag)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [19:0] strobe;
        logic [31:0] data;
    } FrameExp;

    FrameExp expQ[$];
    int      doneQ[$];
    int      errors = 0;
    int      checks = 0;
    int      cycle = 0;
    int      lastAccept = 0;
    int      lastIdx = -1;

    always @(posedge CLK) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expectFrame(input int idx, input logic [31:0] data);
        FrameExp e;
        e.strobe = 20'(1) << idx;
        e.data   = data;
        expQ.push_back(e);
    endtask

    task automatic sendWord(input logic [31:0] w, input int maxGap);
        int waited = 0;
        int gap;
        gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
        repeat (gap) begin
            @(negedge CLK);
            InValid = 1'b0;
            InData  = $urandom;
        end
        @(negedge CLK);
        InData  = w;
        InValid = 1'b1;
        while (!InReady && waited < 50) begin
            @(negedge CLK);
            waited++;
        end
        if (waited >= 50) check("accept_timeout", 32'(waited), 32'd0);
        @(posedge CLK);
        lastAccept = cycle;
        #1;
        InValid = 1'b0;
        InData  = $urandom;
    endtask

    task automatic waitIdle();
        int waited = 0;
        @(negedge CLK);
        while (Busy && waited < 100) begin
            @(negedge CLK);
            waited++;
        end
        if (waited >= 100) check("idle_timeout", 32'(waited), 32'd0);
    endtask

    task automatic releaseReset();
        @(negedge CLK);
        #1;
        RST = 1'b0;
        #1;
        check("ready_after_reset", 32'(InReady), 32'd1);
    endtask

    // Monitor: pops an expectation for every strobe and every Done pulse.
    logic [31:0] prevData = 32'h0;
    logic [19:0] prevStrobe = 20'h0;
    always @(negedge CLK) begin
        if (RST) begin
            prevStrobe = 20'h0;
            prevData   = FrameData;
        end else begin
            if (FrameStrobe != 20'h0) begin
                FrameExp e;
                check("strobe_onehot", 32'($onehot(FrameStrobe)), 32'd1);
                check("setup_stable", FrameData, prevData);
                for (int i = 0; i < 20; i++) if (FrameStrobe[i]) lastIdx = i;
                if (expQ.size() == 0) begin
                    check("strobe_expected", 32'(expQ.size()), 32'd1);
                end else begin
                    e = expQ.pop_front();
                    check("strobe_bits", 32'(FrameStrobe), 32'(e.strobe));
                    check("strobe_data", FrameData, e.data);
                end
            end
            if (prevStrobe != 20'h0) check("hold_stable", FrameData, prevData);
            if (Done) begin
                check("done_busy_low", 32'(Busy), 32'd0);
                if (doneQ.size() == 0) check("unexpected_done", 32'(doneQ.size()), 32'd1);
                else check("done_last_idx", 32'(lastIdx), 32'(doneQ.pop_front()));
            end
            prevStrobe = FrameStrobe;
            prevData   = FrameData;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2;
        int waited;
        logic [31:0] five [5] = '{32'h0102_0304, 32'hFFFF_0000, 32'h0000_FFFF, 32'h5A5A_A5A5, 32'h8000_0001};

        // Reset values
        @(negedge CLK);
        check("rst_framedata", FrameData, 32'h0);
        check("rst_strobe", 32'(FrameStrobe), 32'h0);
        check("rst_ready", 32'(InReady), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_error", 32'(ErrorFlag), 32'd0);
        releaseReset();

        // Single frame at index 0
        expectFrame(0, 32'hDEADBEEF);
        doneQ.push_back(0);
        sendWord(32'hFAB0_0100, 0);
        check("hdr_busy", 32'(Busy), 32'd1);
        check("hdr_ready", 32'(InReady), 32'd1);
        sendWord(32'hDEADBEEF, 0);
        check("setup_data", FrameData, 32'hDEADBEEF);
        check("setup_ready", 32'(InReady), 32'd0);
        waitIdle();
        check("data_kept", FrameData, 32'hDEADBEEF);
        check("error_clear1", 32'(ErrorFlag), 32'd0);

        // Three frames at 17..19, accepts four cycles apart
        expectFrame(17, 32'hAAAA_0001);
        expectFrame(18, 32'hBBBB_0002);
        expectFrame(19, 32'hCCCC_0003);
        doneQ.push_back(19);
        sendWord(32'hFAB0_0311, 0);
        sendWord(32'hAAAA_0001, 0); a0 = lastAccept;
        sendWord(32'hBBBB_0002, 0); a1 = lastAccept;
        sendWord(32'hCCCC_0003, 0); a2 = lastAccept;
        check("spacing_ab", 32'(a1 - a0), 32'd4);
        check("spacing_bc", 32'(a2 - a1), 32'd4);
        waitIdle();

        // Overflowing header: 19 + 2 > 20
        sendWord(32'hFAB0_0213, 0);
        check("ovf_error", 32'(ErrorFlag), 32'd1);
        check("ovf_busy", 32'(Busy), 32'd0);
        expectFrame(0, 32'h1111_1111);
        doneQ.push_back(0);
        sendWord(32'hFAB0_0100, 0);
        check("valid_hdr_clears", 32'(ErrorFlag), 32'd0);
        sendWord(32'h1111_1111, 0);
        waitIdle();

        // Bad sync, then a data-looking word is also rejected as a header
        sendWord(32'h1234_0100, 0);
        check("badsync_error", 32'(ErrorFlag), 32'd1);
        sendWord(32'h0000_0005, 0);
        check("data_as_hdr_error", 32'(ErrorFlag), 32'd1);
        check("data_as_hdr_busy", 32'(Busy), 32'd0);

        // Five frames with random valid gaps and garbage data while idle
        for (int i = 0; i < 5; i++) expectFrame(i, five[i]);
        doneQ.push_back(4);
        sendWord(32'hFAB0_0500, 3);
        check("five_error_clear", 32'(ErrorFlag), 32'd0);
        for (int i = 0; i < 5; i++) sendWord(five[i], 3);
        waitIdle();

        // Reset while the strobe is high
        expectFrame(4, 32'hCAFE_F00D);
        sendWord(32'hFAB0_0204, 0);
        sendWord(32'hCAFE_F00D, 0);
        waited = 0;
        @(negedge CLK);
        while (FrameStrobe == 20'h0 && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        check("strobe_seen", 32'(FrameStrobe != 20'h0), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        check("rst_mid_strobe", 32'(FrameStrobe), 32'h0);
        check("rst_mid_data", FrameData, 32'h0);
        check("rst_mid_busy", 32'(Busy), 32'd0);
        check("rst_mid_ready", 32'(InReady), 32'd0);
        @(negedge CLK);
        releaseReset();
        expectFrame(7, 32'h7777_0007);
        doneQ.push_back(7);
        sendWord(32'hFAB0_0107, 0);
        sendWord(32'h7777_0007, 0);
        waitIdle();

        repeat (5) @(negedge CLK);
        check("exp_queue_empty", 32'(expQ.size()), 32'd0);
        check("done_queue_empty", 32'(doneQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
